// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer.
// Access kinds, buffer FSM states and the entry layout.
package mem_store_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 26;
  localparam int unsigned SB_DATA_W = 32;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_action_t;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_DRAIN_WAIT,
    SB_LOAD_WAIT
  } sb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// D-cache request/response port of the store buffer.
// master = store buffer side, slave = cache side.
interface mem_store_buffer_if
  import mem_store_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) ();

  logic                  o_dc_valid;
  mem_action_t           o_dc_mem_action;
  logic [ADDR_WIDTH-1:0] o_dc_addr;
  logic [DATA_WIDTH-1:0] o_dc_data;
  logic                  i_dc_done;
  logic [DATA_WIDTH-1:0] i_dc_data;

  modport master (
    output o_dc_valid,
    output o_dc_mem_action,
    output o_dc_addr,
    output o_dc_data,
    input  i_dc_done,
    input  i_dc_data
  );

  modport slave (
    input  o_dc_valid,
    input  o_dc_mem_action,
    input  o_dc_addr,
    input  o_dc_data,
    output i_dc_done,
    output i_dc_data
  );

endinterface

// File: rtl/mem_store_buffer_sb_forward_select.sv
// Store-to-load forwarding: compare every entry against the
// load address and pick the youngest hit, walking from head.
module sb_forward_select
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]         i_head,
  input  logic [ADDR_WIDTH-1:0]            i_lookup,
  output logic                             o_hit,
  output logic [DATA_WIDTH-1:0]            o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // oldest to youngest; a later hit overrides an earlier one
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_head + PTR_W'(k);
      if (i_valid[idx] && (i_addr[idx] == i_lookup)) begin
        o_hit  = 1'b1;
        o_data = i_data[idx];
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: retires stores into a FIFO, drains
// them to the D-cache, forwards to loads, drives write-back.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  mem_action_t           i_mem_action,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rw_data,
  mem_store_buffer_if.master    dc,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_state_t state_q, state_d;

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;

  logic                  is_store;
  logic                  is_load;
  logic                  has_room;
  logic                  store_ok;
  logic                  push;
  logic                  pop;
  logic                  load_miss;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  co_hit;
  logic [PTR_W-1:0]      co_idx;

  assign is_store  = i_valid & (i_mem_action == MEM_WRITE);
  assign is_load   = i_valid & (i_mem_action == MEM_READ);
  assign has_room  = (count_q != FULL_CNT);
  assign store_ok  = is_store & has_room;
  assign push      = store_ok & ~co_hit;
  assign pop       = (state_q == SB_DRAIN_WAIT) & dc.i_dc_done;
  assign load_miss = is_load & ~fwd_hit;

  sb_forward_select #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fwd (
    .i_valid  (valid_q),
    .i_addr   (addr_q),
    .i_data   (data_q),
    .i_head   (head_q),
    .i_lookup (i_addr),
    .o_hit    (fwd_hit),
    .o_data   (fwd_data)
  );

  // coalesce target: a live entry other than the (maybe draining) head
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (PTR_W'(i) != head_q) &&
          (addr_q[i] == i_addr)) begin
        co_hit = 1'b1;
        co_idx = PTR_W'(i);
      end
    end
  end

  // FIFO update: coalesce or enqueue at tail, pop head on drain done
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store_ok && co_hit) begin
      data_d[co_idx] = i_data;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = i_addr;
      data_d[tail_q]  = i_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // cache FSM: load miss beats drain; always back through IDLE
  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    unique case (state_q)
      SB_IDLE: begin
        if (load_miss) begin
          state_d   = SB_LOAD_WAIT;
          ld_addr_d = i_addr;
        end else if ((count_q != '0) || push) begin
          state_d = SB_DRAIN_WAIT;
        end
      end
      SB_DRAIN_WAIT: begin
        if (dc.i_dc_done) state_d = SB_IDLE;
      end
      SB_LOAD_WAIT: begin
        if (dc.i_dc_done) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // MEM-stage completion and write-back data select
  always_comb begin
    o_done    = 1'b0;
    o_rw_data = i_alu_result;
    unique case (1'b1)
      !i_valid: o_done = 1'b1;
      is_store: o_done = has_room;
      is_load: begin
        if (fwd_hit) begin
          o_done    = 1'b1;
          o_rw_data = fwd_data;
        end else if ((state_q == SB_LOAD_WAIT) && dc.i_dc_done) begin
          o_done    = 1'b1;
          o_rw_data = dc.i_dc_data;
        end
      end
      default: o_done = 1'b0;
    endcase
  end

  // cache request comes purely from registered state
  always_comb begin
    dc.o_dc_valid      = (state_q != SB_IDLE);
    dc.o_dc_mem_action = MEM_WRITE;
    dc.o_dc_addr       = addr_q[head_q];
    dc.o_dc_data       = data_q[head_q];
    if (state_q == SB_LOAD_WAIT) begin
      dc.o_dc_mem_action = MEM_READ;
      dc.o_dc_addr       = ld_addr_q;
    end
  end

  assign o_empty = (count_q == '0) && (state_q == SB_IDLE);
  assign o_full  = (count_q == FULL_CNT);

  // state and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SB_IDLE;
      valid_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ld_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ld_addr_q <= ld_addr_d;
    end
  end

endmodule
